sd_spi_byte_engine: RTL and testbench
=====================================

Name: sd_spi_byte_engine

Overview:
- Avalon-MM slave that replaces software bit-banging of the SD card clock with a hardware SPI-mode-0 byte shifter.
- Generates sd_clk at a programmable rate, shifts one command byte out on sd_cmd (MOSI), and samples one response byte from sd_dat0 (MISO).
- Sits beside the Nios SD loader PIOs. The CPU writes a byte, polls busy or takes the IRQ, then reads the response.

Parameters:
- DIV_RESET, 16'd124, reset value of the divider register. Half-period = DIV+1 clk cycles; 200 kHz at 50 MHz.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address; no wait states
- irq  out  1  done & irq_en
- sd_clk  out  1  SPI clock, idle low
- sd_cmd  out  1  MOSI
- sd_dat0  in  1  MISO, already synchronised externally
- sd_cs_n  out  1  card select, active low

Behaviour:
- Reset/clock: reset_n is asynchronous and active-low; clk is the clock.
- Reset values:
  - sd_clk=0, sd_cmd=1, sd_cs_n=1, irq=0
  - busy=0, done=0, irq_en=0
  - rx=8'h00, div=DIV_RESET
  - FSM=IDLE
- Write decode: chipselect & ~write_n.
- Register map:
  - Addr 0 DATA:
    - Write while idle: loads tx shift register, latches div into div_active, clears done, sets busy on the next edge.
    - Write while busy: ignored; no state change.
    - Read: {24'b0, rx}.
  - Addr 1 STATUS:
    - Read: {30'b0, done, busy}.
    - Any write clears done.
  - Addr 2 DIVIDER:
    - Read/write: bits [15:0].
    - A write during a transfer changes only the register; the running transfer keeps using div_active.
  - Addr 3 CONTROL:
    - bit0 cs_n, reset 1; drives sd_cs_n directly and takes effect even mid-transfer.
    - bit1 irq_en.
    - Read: {30'b0, irq_en, cs_n}.
- FSM states IDLE, LOW, HIGH; 16-bit half-period counter cnt; 3-bit bit_cnt.
  - IDLE:
    - sd_clk=0, sd_cmd=1.
    - On start: sd_cmd=tx[7], cnt=div_active, bit_cnt=0, go to LOW.
  - LOW:
    - cnt≠0: decrement.
    - cnt=0: sd_clk<=1, rx_shift<={rx_shift[6:0], sd_dat0}, cnt=div_active, go to HIGH.
  - HIGH:
    - cnt≠0: decrement.
    - cnt=0: sd_clk<=0, then:
      - bit_cnt=7: rx<=rx_shift, busy<=0, done<=1, sd_cmd<=1, go to IDLE.
      - otherwise: shift tx left, sd_cmd<=next bit, bit_cnt++, go to LOW.
- Timing:
  - Each bit is 2*(div_active+1) clk: sd_clk low for div+1 cycles, high for div+1 cycles.
  - busy rises 1 cycle after the DATA write and falls exactly 16*(div_active+1) cycles later.
  - MSB first.
  - MISO is sampled on the edge that drives sd_clk high.
  - MOSI changes only together with the falling sd_clk edge, or at start.
- div=0 is legal: 1-cycle half-periods, sd_clk = clk/2.
- rx updates only at transfer end; reading DATA mid-transfer returns the previous byte.
- Same-cycle events:
  - STATUS write in the cycle done sets: set wins; done=1.
  - DATA write in the cycle busy falls: ignored, because busy is still 1 in that cycle.
- Reset mid-transfer: returns immediately to reset values; no partial rx update.

Test Plan:
- Reset -> reads: DATA=0, STATUS=0, DIVIDER=124, CONTROL=1; sd_cs_n=1, sd_cmd=1, sd_clk=0, irq=0.
- DIV=0, CONTROL=0, write DATA=0xA5, model drives MISO 0x3C -> 8 sd_clk pulses each 1 cycle high, MOSI 1,0,1,0,0,1,0,1, busy high for 16 cycles, STATUS=0x2, DATA read=0x3C.
- DIV=2, write 0xFF -> sd_clk high 3 cycles and low 3 cycles; busy high for exactly 48 cycles.
- Mid-transfer: write DATA=0x00 and DIVIDER=5 -> transfer still sends 0xFF with 48-cycle timing. Next transfer uses 12-cycle bits; DIVIDER reads 5.
- irq_en=1, transfer completes -> irq=1. STATUS write -> irq=0 next cycle. STATUS write coincident with completion -> done stays 1.
- Assert reset_n at bit 4 of a transfer -> outputs return to reset values asynchronously, rx keeps 0, next transfer works normally.

Source files
------------

// File: rtl/sd_spi_byte_engine_if.sv
// Avalon-MM slave bus carrying CPU register accesses into the SD SPI byte engine.
interface sd_spi_byte_engine_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte shifter for SD card boot: one byte out on sd_cmd, one byte in from sd_dat0.
// A byte takes 16*(div+1) clk; no backpressure, DATA writes while busy are dropped.
module sd_spi_byte_engine #(
  parameter logic [15:0] DIV_RESET = 16'd124
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sd_spi_byte_engine_if.slave  avs,
  output logic                 irq,
  output logic                 sd_clk,
  output logic                 sd_cmd,
  input  logic                 sd_dat0,
  output logic                 sd_cs_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic [1:0]  state_q,      state_d;
  logic [15:0] cnt_q,        cnt_d;
  logic [2:0]  bit_cnt_q,    bit_cnt_d;
  logic [7:0]  tx_q,         tx_d;
  logic [7:0]  rx_shift_q,   rx_shift_d;
  logic [7:0]  rx_q,         rx_d;
  logic [15:0] div_q,        div_d;
  logic [15:0] div_active_q, div_active_d;
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        irq_en_q,     irq_en_d;
  logic        cs_n_q,       cs_n_d;
  logic        sd_clk_q,     sd_clk_d;
  logic        sd_cmd_q,     sd_cmd_d;

  logic        wr;
  logic        start;
  logic [31:0] rdata;
  logic        wdata_hi_unused;

  assign wr              = avs.chipselect & ~avs.write_n;
  assign start           = wr && (avs.address == A_DATA) && !busy_q;
  assign wdata_hi_unused = ^avs.writedata[31:16];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_shift_d   = rx_shift_q;
    rx_d         = rx_q;
    div_d        = div_q;
    div_active_d = div_active_q;
    busy_d       = busy_q;
    done_d       = done_q;
    irq_en_d     = irq_en_q;
    cs_n_d       = cs_n_q;
    sd_clk_d     = sd_clk_q;
    sd_cmd_d     = sd_cmd_q;

    // Register writes first so a done-set from the FSM below wins over a STATUS clear.
    if (wr) begin
      case (avs.address)
        A_STATUS: done_d = 1'b0;
        A_DIV:    div_d  = avs.writedata[15:0];
        A_CTRL: begin
          cs_n_d   = avs.writedata[0];
          irq_en_d = avs.writedata[1];
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        sd_clk_d = 1'b0;
        sd_cmd_d = 1'b1;
        if (start) begin
          tx_d         = avs.writedata[7:0];
          sd_cmd_d     = avs.writedata[7];
          div_active_d = div_q;
          cnt_d        = div_q;
          bit_cnt_d    = 3'd0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_LOW;
        end
      end

      ST_LOW: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          sd_clk_d   = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], sd_dat0};
          cnt_d      = div_active_q;
          state_d    = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          sd_clk_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            rx_d     = rx_shift_q;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            sd_cmd_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            // Next MOSI bit launches with the falling clock edge.
            tx_d      = {tx_q[6:0], 1'b0};
            sd_cmd_d  = tx_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
            cnt_d     = div_active_q;
            state_d   = ST_LOW;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      bit_cnt_q    <= 3'd0;
      tx_q         <= 8'h00;
      rx_shift_q   <= 8'h00;
      rx_q         <= 8'h00;
      div_q        <= DIV_RESET;
      div_active_q <= DIV_RESET;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      cs_n_q       <= 1'b1;
      sd_clk_q     <= 1'b0;
      sd_cmd_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_shift_q   <= rx_shift_d;
      rx_q         <= rx_d;
      div_q        <= div_d;
      div_active_q <= div_active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      irq_en_q     <= irq_en_d;
      cs_n_q       <= cs_n_d;
      sd_clk_q     <= sd_clk_d;
      sd_cmd_q     <= sd_cmd_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (avs.address)
      A_DATA:   rdata = {24'h0, rx_q};
      A_STATUS: rdata = {30'h0, done_q, busy_q};
      A_DIV:    rdata = {16'h0, div_q};
      A_CTRL:   rdata = {30'h0, irq_en_q, cs_n_q};
      default:  rdata = 32'h0;
    endcase
  end

  assign avs.readdata = rdata;
  assign irq          = done_q & irq_en_q;
  assign sd_clk       = sd_clk_q;
  assign sd_cmd       = sd_cmd_q;
  assign sd_cs_n      = cs_n_q;

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Directed + randomized bench for sd_spi_byte_engine with an SD-card MISO model.
module tb_sd_spi_byte_engine;

  logic clk = 1'b0;
  logic reset_n;
  logic irq, sd_clk, sd_cmd, sd_cs_n;
  logic sd_dat0;

  sd_spi_byte_engine_if bus ();

  sd_spi_byte_engine #(.DIV_RESET(16'd124)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .irq     (irq),
    .sd_clk  (sd_clk),
    .sd_cmd  (sd_cmd),
    .sd_dat0 (sd_dat0),
    .sd_cs_n (sd_cs_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Card/line observer: cycle stamps of sd_clk edges, MOSI captured at each rise.
  int         ncyc = 0;
  int         rise_t[$];
  int         fall_t[$];
  int         rise_cnt = 0;
  logic [7:0] mosi_byte = 8'h00;
  logic [7:0] miso_byte = 8'hFF;
  logic       prev_clk = 1'b0;

  // Card presents the next response bit MSB first, advancing after each rising edge.
  assign sd_dat0 = (rise_cnt < 8) ? miso_byte[3'(7 - rise_cnt)] : 1'b1;

  always @(posedge clk) ncyc++;

  always @(negedge clk) begin
    if (sd_clk === 1'b1 && prev_clk === 1'b0) begin
      rise_t.push_back(ncyc);
      mosi_byte = {mosi_byte[6:0], sd_cmd};
      rise_cnt++;
    end
    if (sd_clk === 1'b0 && prev_clk === 1'b1) fall_t.push_back(ncyc);
    prev_clk = sd_clk;
  end

  // Reference state: what software should see.
  logic [7:0] last_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic clear_obs(input logic [7:0] resp);
    @(posedge clk);
    #1;
    rise_t.delete();
    fall_t.delete();
    rise_cnt  = 0;
    mosi_byte = 8'h00;
    miso_byte = resp;
  endtask

  // One byte exchange; d is the divider the transfer is expected to run with.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] resp, input int d,
                      input bit mid, input string tag);
    int t0, t_end, bad, hp;
    logic [31:0] rd;
    hp = d + 1;
    clear_obs(resp);
    bus_write(2'd0, {24'h0, tx});
    bus.address = 2'd0;
    @(negedge clk);
    t0 = ncyc;
    chk({tag, " rx-during"}, bus.readdata, {24'h0, last_rx});
    if (mid) begin
      @(posedge clk);
      #1;
      bus_write(2'd0, 32'h0);
      bus_write(2'd2, 32'd5);
    end
    bus.address = 2'd1;
    t_end = -1;
    for (int g = 0; g < 5000; g++) begin
      @(negedge clk);
      if (bus.readdata[0] === 1'b0) begin
        t_end = ncyc;
        break;
      end
    end
    #1;
    chk({tag, " busy-len"}, t_end - t0, 16 * hp);
    chk({tag, " pulses"}, rise_t.size() + fall_t.size(), 16);
    bad = 0;
    foreach (rise_t[i]) if (rise_t[i] - t0 != (2 * i + 1) * hp) bad++;
    foreach (fall_t[i]) if (fall_t[i] - t0 != (2 * i + 2) * hp) bad++;
    chk({tag, " edge-timing-errs"}, bad, 0);
    chk({tag, " mosi"}, mosi_byte, tx);
    chk({tag, " idle-lines"}, {sd_clk, sd_cmd}, 2'b01);
    bus_read(2'd0, rd);
    chk({tag, " rx"}, rd, {24'h0, resp});
    last_rx = resp;
    bus_read(2'd1, rd);
    chk({tag, " status"}, rd, 32'h2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  tx, rsp;
    int          d;

    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    last_rx        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    bus_read(2'd0, rd); chk("reset DATA", rd, 32'h0);
    bus_read(2'd1, rd); chk("reset STATUS", rd, 32'h0);
    bus_read(2'd2, rd); chk("reset DIVIDER", rd, 32'd124);
    bus_read(2'd3, rd); chk("reset CONTROL", rd, 32'h1);
    chk("reset pins", {sd_cs_n, sd_cmd, sd_clk, irq}, 4'b1100);

    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd0);
    #1;
    chk("cs_n low", sd_cs_n, 1'b0);
    xfer(8'hA5, 8'h3C, 0, 1'b0, "div0");

    bus_write(2'd2, 32'd2);
    xfer(8'hFF, 8'h81, 2, 1'b0, "div2");
    xfer(8'hFF, 8'h5E, 2, 1'b1, "div2-mid");
    bus_read(2'd2, rd); chk("divider after mid", rd, 32'd5);
    xfer(8'h96, 8'h69, 5, 1'b0, "div5");

    for (int k = 0; k < 4; k++) begin
      tx  = 8'($urandom);
      rsp = 8'($urandom);
      d   = $urandom_range(0, 3);
      bus_write(2'd2, 32'(d));
      bus_read(2'd2, rd);
      chk("rand divider", rd, 32'(d));
      xfer(tx, rsp, d, 1'b0, "rand");
    end

    bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'h2);
    xfer(8'h3A, 8'hC5, 1, 1'b0, "irq");
    chk("irq set", irq, 1'b1);
    bus_write(2'd1, 32'h0);
    @(negedge clk);
    chk("irq cleared", irq, 1'b0);

    // STATUS write landing on the very edge that sets done.
    clear_obs(8'h77);
    bus_write(2'd0, 32'h0C);
    repeat (16 * 2 - 1) @(posedge clk);
    #1;
    bus_write(2'd1, 32'h0);
    bus_read(2'd1, rd);
    chk("coincident status", rd, 32'h2);
    chk("coincident irq", irq, 1'b1);
    bus_read(2'd0, rd);
    chk("coincident rx", rd, 32'h77);
    last_rx = 8'h77;

    // Reset during bit 4 of a transfer.
    bus_write(2'd2, 32'd2);
    clear_obs(8'hC3);
    bus_write(2'd0, 32'h00);
    for (int g = 0; g < 500 && rise_cnt < 5; g++) @(negedge clk);
    #2;
    chk("pre-reset sd_clk high", sd_clk, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async reset pins", {sd_cs_n, sd_cmd, sd_clk, irq}, 4'b1100);
    bus_read(2'd0, rd); chk("reset rx", rd, 32'h0);
    bus_read(2'd1, rd); chk("reset status mid", rd, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    last_rx = 8'h00;
    bus_read(2'd2, rd); chk("reset divider mid", rd, 32'd124);
    bus_write(2'd2, 32'd1);
    xfer(8'($urandom), 8'($urandom), 1, 1'b0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
